// File: rtl/lia_demodulator.sv
// lia_demodulator: lock-in mixer stage, NCO sine reference plus a 4-stage demodulation multiplier.
// Define LIA_QUADRATURE_EN to add the cosine (Q) demodulation path.
module lia_demodulator #(
    parameter int phase_width = 32,
    parameter int lut_pow     = 10,
    parameter int word_width  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic        [phase_width-1:0] freq_word,
    input  logic        [phase_width-1:0] phase_offset,
    input  logic signed [word_width-1:0]  sample_in,
    input  logic                          sample_in_valid,
    output logic signed [word_width-1:0]  ref_out,
    output logic signed [word_width-1:0]  demod_out,
    output logic                          demod_out_valid
`ifdef LIA_QUADRATURE_EN
    ,
    output logic signed [word_width-1:0]  demod_q_out,
    output logic                          demod_q_out_valid
`endif
);

    localparam int LUT_DEPTH = 1 << lut_pow;
    localparam int PROD_W    = 2 * word_width;

    localparam logic signed [PROD_W:0] RND_HALF =
        {{(word_width + 2){1'b0}}, 1'b1, {(word_width - 2){1'b0}}};
    localparam logic signed [PROD_W:0] SAT_MAX =
        {{(word_width + 2){1'b0}}, {(word_width - 1){1'b1}}};
    localparam logic signed [PROD_W:0] SAT_MIN =
        {{(word_width + 2){1'b1}}, {(word_width - 1){1'b0}}};

    // Amplitude is 2^(W-1)-1 so the table is symmetric and never holds the most negative code.
    function automatic logic signed [word_width-1:0] sine_entry(input int k);
        real amp;
        real x;
        int  v;
        amp = real'((1 << (word_width - 1)) - 1);
        x   = amp * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH));
        v   = (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
        return word_width'(v);
    endfunction

    function automatic logic signed [PROD_W-1:0] mult_full(
        input logic signed [word_width-1:0] a,
        input logic signed [word_width-1:0] b
    );
        return $signed({{word_width{a[word_width-1]}}, a}) *
               $signed({{word_width{b[word_width-1]}}, b});
    endfunction

    // Round half up at bit W-1, then clamp to the output word range.
    function automatic logic signed [word_width-1:0] round_sat(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W:0] s;
        logic signed [PROD_W:0] sh;
        s  = $signed({p[PROD_W-1], p}) + RND_HALF;
        sh = s >>> (word_width - 1);
        if (sh > SAT_MAX) begin
            return SAT_MAX[word_width-1:0];
        end else if (sh < SAT_MIN) begin
            return SAT_MIN[word_width-1:0];
        end
        return sh[word_width-1:0];
    endfunction

    logic signed [word_width-1:0] lut_rom [LUT_DEPTH];

    for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_lut
        assign lut_rom[k] = sine_entry(k);
    end

    logic        [phase_width-1:0] acc;
    logic        [phase_width-1:0] phase_sum;
    logic        [lut_pow-1:0]     ref_addr;
    logic        [lut_pow-1:0]     phase_addr;
    logic                          unused_phase_bits;

    assign phase_sum         = acc + phase_offset;
    assign ref_addr          = acc[phase_width-1 -: lut_pow];
    assign phase_addr        = phase_sum[phase_width-1 -: lut_pow];
    assign unused_phase_bits = ^{phase_sum[phase_width-lut_pow-1:0],
                                 acc[phase_width-lut_pow-1:0]};

    logic                          vld_p1, vld_p2, vld_p3;
    logic signed [word_width-1:0]  samp_p1, samp_p2;
    logic        [lut_pow-1:0]     addr_p1;
    logic signed [word_width-1:0]  lut_p2;
    logic signed [PROD_W-1:0]      prod_p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc             <= '0;
            ref_out         <= '0;
            vld_p1          <= 1'b0;
            vld_p2          <= 1'b0;
            vld_p3          <= 1'b0;
            samp_p1         <= '0;
            samp_p2         <= '0;
            addr_p1         <= '0;
            lut_p2          <= '0;
            prod_p3         <= '0;
            demod_out       <= '0;
            demod_out_valid <= 1'b0;
        end else begin
            acc     <= acc + freq_word;
            ref_out <= lut_rom[ref_addr];

            // p1: accept sample and capture the offset reference phase
            vld_p1 <= sample_in_valid;
            if (sample_in_valid) begin
                samp_p1 <= sample_in;
                addr_p1 <= phase_addr;
            end

            // p2: second LUT read port, independent of ref_out
            vld_p2  <= vld_p1;
            samp_p2 <= samp_p1;
            lut_p2  <= lut_rom[addr_p1];

            // p3: full-precision signed product
            vld_p3  <= vld_p2;
            prod_p3 <= mult_full(samp_p2, lut_p2);

            // p4: round, saturate, hold value between strobes
            demod_out_valid <= vld_p3;
            if (vld_p3) begin
                demod_out <= round_sat(prod_p3);
            end
        end
    end

`ifdef LIA_QUADRATURE_EN
    localparam logic [lut_pow-1:0] QUARTER = {2'b01, {(lut_pow - 2){1'b0}}};

    logic signed [word_width-1:0] lut_q_p2;
    logic signed [PROD_W-1:0]     prod_q_p3;

    // Quarter-cycle address offset turns the sine table into cosine; valid is shared with I.
    always_ff @(posedge clk) begin
        if (rst) begin
            lut_q_p2    <= '0;
            prod_q_p3   <= '0;
            demod_q_out <= '0;
        end else begin
            lut_q_p2  <= lut_rom[addr_p1 + QUARTER];
            prod_q_p3 <= mult_full(samp_p2, lut_q_p2);
            if (vld_p3) begin
                demod_q_out <= round_sat(prod_q_p3);
            end
        end
    end

    assign demod_q_out_valid = demod_out_valid;
`endif

endmodule
